// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer driven by a synchronised, edge-detected one-second tick.
// Commands are single-cycle pulses; digits feed the display-decoder stage directly.
module bcd_countdown_timer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       running,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [3:0]             mt_q, mt_d, mu_q, mu_d, st_q, st_d, su_q, su_d;
  logic                   running_q, running_d;
  logic                   done_q, done_d;
  logic                   expired_q, expired_d;
  logic                   tick, is_zero, is_one;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], tick_in};
    hist_d    = sync_q[SYNC_STAGES-1];
    tick      = sync_q[SYNC_STAGES-1] & ~hist_q;
    is_zero   = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd0);
    is_one    = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd1);

    state_d   = state_q;
    mt_d      = mt_q;
    mu_d      = mu_q;
    st_d      = st_q;
    su_d      = su_q;
    expired_d = 1'b0;

    if (clear) begin
      state_d = IDLE;
      mt_d    = '0;
      mu_d    = '0;
      st_d    = '0;
      su_d    = '0;
    end else if (load && state_q != RUN) begin
      state_d = IDLE;
      mt_d    = clamp(load_mm[7:4], 4'd9);
      mu_d    = clamp(load_mm[3:0], 4'd9);
      st_d    = clamp(load_ss[7:4], 4'd5);
      su_d    = clamp(load_ss[3:0], 4'd9);
    end else if (pause && state_q == RUN) begin
      state_d = PAUSED;
    end else if (start && (state_q == IDLE || state_q == PAUSED) && !is_zero) begin
      state_d = RUN;
    end else if (state_q == RUN && tick && !is_zero) begin
      // Borrow ripples right to left; the zero guard above prevents underflow.
      if (su_q != 4'd0) begin
        su_d = su_q - 4'd1;
      end else begin
        su_d = 4'd9;
        if (st_q != 4'd0) begin
          st_d = st_q - 4'd1;
        end else begin
          st_d = 4'd5;
          if (mu_q != 4'd0) begin
            mu_d = mu_q - 4'd1;
          end else begin
            mu_d = 4'd9;
            mt_d = mt_q - 4'd1;
          end
        end
      end
      if (is_one) begin
        state_d   = DONE;
        expired_d = 1'b1;
      end
    end

    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      hist_q    <= 1'b0;
      mt_q      <= '0;
      mu_q      <= '0;
      st_q      <= '0;
      su_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      mt_q      <= mt_d;
      mu_q      <= mu_d;
      st_q      <= st_d;
      su_q      <= su_d;
      running_q <= running_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign min_tens  = mt_q;
  assign min_units = mu_q;
  assign sec_tens  = st_q;
  assign sec_units = su_q;
  assign running   = running_q;
  assign done      = done_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed plan plus random commands, checked against
// an integer-seconds reference model with a latency queue for the tick path.
module tb_bcd_countdown_timer;
  localparam int SYNC = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1, tick_in = 1'b0, clear = 1'b0, load = 1'b0;
  logic       start = 1'b0, pause = 1'b0;
  logic [7:0] load_mm = '0, load_ss = '0;
  logic [3:0] min_tens, min_units, sec_tens, sec_units;
  logic       running, done, expired;

  int errors = 0;
  int checks = 0;
  int exp_seen = 0;

  bcd_countdown_timer #(.SYNC_STAGES(SYNC)) dut (
    .clock_in (clk),
    .reset    (reset),
    .tick_in  (tick_in),
    .clear    (clear),
    .load     (load),
    .load_mm  (load_mm),
    .load_ss  (load_ss),
    .start    (start),
    .pause    (pause),
    .min_tens (min_tens),
    .min_units(min_units),
    .sec_tens (sec_tens),
    .sec_units(sec_units),
    .running  (running),
    .done     (done),
    .expired  (expired)
  );

  always #5 clk = ~clk;

  // Reference model: remaining time as plain seconds, tick latency as a due-cycle queue.
  int m_secs = 0, m_mode = M_IDLE, cyc = 0;
  bit m_exp = 1'b0, m_prev = 1'b0;
  int due_q[$];

  function automatic int clampv(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  always @(posedge clk) begin
    bit t;
    cyc++;
    t = 1'b0;
    if (reset) begin
      m_secs = 0; m_mode = M_IDLE; m_exp = 1'b0; m_prev = 1'b0;
      due_q.delete();
    end else begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        t = 1'b1;
        void'(due_q.pop_front());
      end
      if (tick_in && !m_prev) due_q.push_back(cyc + SYNC);
      m_prev = tick_in;
      m_exp = 1'b0;
      if (clear) begin
        m_secs = 0; m_mode = M_IDLE;
      end else if (load && m_mode != M_RUN) begin
        m_secs = (clampv(load_mm[7:4], 9) * 10 + clampv(load_mm[3:0], 9)) * 60
               + clampv(load_ss[7:4], 5) * 10 + clampv(load_ss[3:0], 9);
        m_mode = M_IDLE;
      end else if (pause && m_mode == M_RUN) begin
        m_mode = M_PAUSED;
      end else if (start && (m_mode == M_IDLE || m_mode == M_PAUSED) && m_secs != 0) begin
        m_mode = M_RUN;
      end else if (m_mode == M_RUN && t && m_secs > 0) begin
        m_secs--;
        if (m_secs == 0) begin
          m_mode = M_DONE; m_exp = 1'b1;
        end
      end
    end
  end

  function automatic logic [15:0] to_bcd(input int s);
    logic [15:0] r;
    r[15:12] = 4'((s / 600));
    r[11:8]  = 4'((s / 60) % 10);
    r[7:4]   = 4'((s % 60) / 10);
    r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic chk_all();
    chk("digits_vs_model", {16'h0, min_tens, min_units, sec_tens, sec_units}, {16'h0, to_bcd(m_secs)});
    chk("running_vs_model", {31'h0, running}, {31'h0, m_mode == M_RUN});
    chk("done_vs_model", {31'h0, done}, {31'h0, m_mode == M_DONE});
    chk("expired_vs_model", {31'h0, expired}, {31'h0, m_exp});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (expired === 1'b1) exp_seen++;
      chk_all();
    end
  endtask

  task automatic chk_val(input string tag, input logic [15:0] v, input logic r, input logic d);
    chk({tag, "_digits"}, {16'h0, min_tens, min_units, sec_tens, sec_units}, {16'h0, v});
    chk({tag, "_running"}, {31'h0, running}, {31'h0, r});
    chk({tag, "_done"}, {31'h0, done}, {31'h0, d});
  endtask

  task automatic do_load(input logic [7:0] mm, input logic [7:0] ss);
    load_mm = mm; load_ss = ss; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1; step(1); pause = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      tick_in = 1'b1; step(4);
      tick_in = 1'b0; step(4);
    end
  endtask

  initial begin
    // Reset held with tick_in toggling
    repeat (3) begin
      @(negedge clk); tick_in = ~tick_in;
    end
    @(negedge clk);
    chk_val("reset", 16'h0000, 1'b0, 1'b0);
    chk("reset_expired", {31'h0, expired}, 32'h0);
    tick_in = 1'b0;
    reset = 1'b0;
    step(4);

    // Full countdown from 01:00
    do_load(8'h01, 8'h00);
    do_start();
    chk_val("start_0100", 16'h0100, 1'b1, 1'b0);
    exp_seen = 0;
    do_ticks(1);
    chk_val("first_tick", 16'h0059, 1'b1, 1'b0);
    do_ticks(59);
    chk_val("countdown_end", 16'h0000, 1'b0, 1'b1);
    chk("expired_once", exp_seen, 32'd1);
    do_ticks(3);
    chk_val("after_done", 16'h0000, 1'b0, 1'b1);
    chk("expired_no_repeat", exp_seen, 32'd1);

    // Borrow chain; load in DONE returns to IDLE
    do_load(8'h10, 8'h00);
    chk_val("load_in_done", 16'h1000, 1'b0, 1'b0);
    do_start();
    do_ticks(1);
    chk_val("borrow_1000", 16'h0959, 1'b1, 1'b0);
    do_pause();
    do_load(8'h00, 8'h10);
    do_start();
    do_ticks(1);
    chk_val("borrow_0010", 16'h0009, 1'b1, 1'b0);

    // Pause, resume, pause beats start
    do_pause();
    do_load(8'h05, 8'h30);
    do_start();
    do_pause();
    do_ticks(5);
    chk_val("paused_hold", 16'h0530, 1'b0, 1'b0);
    do_start();
    do_ticks(1);
    chk_val("resume", 16'h0529, 1'b1, 1'b0);
    start = 1'b1; pause = 1'b1; step(1); start = 1'b0; pause = 1'b0;
    chk_val("pause_over_start", 16'h0529, 1'b0, 1'b0);

    // Load clamping and load ignored in RUN
    do_load(8'h7F, 8'hAB);
    chk_val("clamp", 16'h7959, 1'b0, 1'b0);
    do_start();
    do_load(8'h12, 8'h34);
    chk_val("load_in_run", 16'h7959, 1'b1, 1'b0);
    do_clear();
    do_start();
    chk_val("start_at_zero", 16'h0000, 1'b0, 1'b0);

    // Reset mid-run with a tick in flight
    do_load(8'h03, 8'h17);
    do_start();
    tick_in = 1'b1; step(1);
    reset = 1'b1; tick_in = 1'b0; step(1);
    chk_val("reset_mid_run", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    do_load(8'h00, 8'h05);
    do_start();
    step(6);
    chk_val("no_inflight_tick", 16'h0005, 1'b1, 1'b0);

    // Clear on the same edge the tick decrement would land
    tick_in = 1'b1; step(2);
    clear = 1'b1; step(1); clear = 1'b0;
    chk_val("clear_vs_tick", 16'h0000, 1'b0, 1'b0);
    tick_in = 1'b0; step(4);

    // Random commands and tick edges against the model
    for (int i = 0; i < 1500; i++) begin
      int r;
      if ($urandom_range(0, 5) == 0) tick_in = ~tick_in;
      r = $urandom_range(0, 99);
      load = (r < 4);
      start = (r >= 4 && r < 14) || (r == 99);
      pause = (r >= 14 && r < 18) || (r == 99);
      clear = (r == 18);
      reset = (r == 19);
      load_mm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      load_ss = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 8'h15)) : 8'($urandom);
      step(1);
    end
    {load, start, pause, clear, reset} = '0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
